// File: rtl/pim_banked_buffer_if.sv
// Request/response bus for pim_banked_buffer.
// Optional feature macro: PIM_BUF_PARITY_EN adds o_parity_err to the response side.
interface pim_banked_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_write;
  logic [31:0]             i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_be;
  logic [7:0]              i_req_burst_len;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    o_rsp_last;
  logic                    o_busy;
  logic                    o_addr_err;
`ifdef PIM_BUF_PARITY_EN
  logic                    o_parity_err;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be, i_req_burst_len, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_last, o_busy, o_addr_err, o_parity_err
  );
  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be, i_req_burst_len, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_last, o_busy, o_addr_err, o_parity_err
  );
`else
  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be, i_req_burst_len, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_last, o_busy, o_addr_err
  );
  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be, i_req_burst_len, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_last, o_busy, o_addr_err
  );
`endif
endinterface

// File: rtl/pim_banked_buffer.sv
// Word-interleaved multi-bank buffer with byte-enabled writes and wrapping read bursts
// delivered through a 2-entry response FIFO.
// Optional feature macro: PIM_BUF_PARITY_EN (per-byte even parity, o_parity_err on the bus).
module pim_banked_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 7168
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  pim_banked_buffer_if.slave    bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;
  localparam int WIDX_W = $clog2(TOTAL);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem_r [NUM_BANKS][BANK_DEPTH];

  state_t                state_r, state_nxt_s;
  logic [WIDX_W-1:0]     cur_w_r;
  logic [7:0]            beat_r, len_r;
  logic                  oor_r;
  logic [DATA_WIDTH-1:0] fifo_data_r [2];
  logic                  fifo_last_r [2];
  logic                  wr_ptr_r, rd_ptr_r;
  logic [1:0]            cnt_r, cnt_nxt_s;
  logic                  ready_r, busy_r, addr_err_r;

  logic [31:0]           req_w_s;
  logic                  in_range_s, acc_s, pop_s, issue_s, wr_en_s, last_beat_s;
  logic [WIDX_W-1:0]     acc_w_s;
  logic [BANK_W-1:0]     bank_s;
  logic [ROW_W-1:0]      row_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  assign req_w_s     = bus.i_req_addr >> OFF_W;
  assign in_range_s  = (req_w_s < $unsigned(32'(TOTAL)));
  assign acc_s       = bus.i_req_valid && ready_r;
  assign pop_s       = (cnt_r != 2'd0) && bus.i_rsp_ready;
  // A slot freed by this edge's pop may be refilled on the same edge.
  assign issue_s     = (state_r == ST_BURST) && ((cnt_r != 2'd2) || pop_s);
  assign wr_en_s     = acc_s && bus.i_req_write && in_range_s;
  assign last_beat_s = (beat_r == len_r);

  // Single port per bank: writes only happen in IDLE, reads only in BURST.
  assign acc_w_s   = (state_r == ST_IDLE) ? req_w_s[WIDX_W-1:0] : cur_w_r;
  assign bank_s    = BANK_W'(acc_w_s % WIDX_W'(NUM_BANKS));
  assign row_s     = ROW_W'(acc_w_s / WIDX_W'(NUM_BANKS));
  assign rd_word_s = mem_r[bank_s][row_s];

`ifdef PIM_BUF_PARITY_EN
  logic [NBYTES-1:0] par_mem_r [NUM_BANKS][BANK_DEPTH];
  logic              fifo_perr_r [2];
  logic              rd_perr_s;

  function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NBYTES-1:0] p;
    for (int b = 0; b < NBYTES; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  assign rd_perr_s = |(byte_parity(rd_word_s) ^ par_mem_r[bank_s][row_s]);

  // Parity store: recompute only the bytes being written.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.i_req_be[b]) par_mem_r[bank_s][row_s][b] <= ^bus.i_req_wdata[b*8 +: 8];
      end
    end
  end

  // Parity error bit travels with each FIFO entry; out-of-range beats never flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fifo_perr_r[0] <= 1'b0;
      fifo_perr_r[1] <= 1'b0;
    end else if (issue_s) begin
      fifo_perr_r[wr_ptr_r] <= oor_r ? 1'b0 : rd_perr_s;
    end
  end

  assign bus.o_parity_err = (cnt_r != 2'd0) && fifo_perr_r[rd_ptr_r];
`endif

  // Bank storage: byte-enabled write committed on the acceptance edge; never reset.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.i_req_be[b]) mem_r[bank_s][row_s][b*8 +: 8] <= bus.i_req_wdata[b*8 +: 8];
      end
    end
  end

  // Next state and next FIFO occupancy, used for the registered ready/busy flags.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (acc_s && !bus.i_req_write) state_nxt_s = ST_BURST;
        else                           state_nxt_s = ST_IDLE;
      end
      ST_BURST: begin
        if (issue_s && last_beat_s) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_BURST;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    cnt_nxt_s = cnt_r + 2'(issue_s) - 2'(pop_s);
  end

  // Burst FSM, response FIFO and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r        <= ST_IDLE;
      cur_w_r        <= {WIDX_W{1'b0}};
      beat_r         <= 8'd0;
      len_r          <= 8'd0;
      oor_r          <= 1'b0;
      fifo_data_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_data_r[1] <= {DATA_WIDTH{1'b0}};
      fifo_last_r[0] <= 1'b0;
      fifo_last_r[1] <= 1'b0;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      cnt_r          <= 2'd0;
      ready_r        <= 1'b0;
      busy_r         <= 1'b0;
      addr_err_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ready_r    <= (state_nxt_s == ST_IDLE) && (cnt_nxt_s != 2'd2);
      busy_r     <= (state_nxt_s != ST_IDLE);
      addr_err_r <= acc_s && !in_range_s;
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case (state_r)
        ST_IDLE: begin
          if (acc_s && !bus.i_req_write) begin
            cur_w_r <= in_range_s ? req_w_s[WIDX_W-1:0] : {WIDX_W{1'b0}};
            beat_r  <= 8'd0;
            len_r   <= bus.i_req_burst_len;
            oor_r   <= !in_range_s;
          end
        end
        ST_BURST: begin
          if (issue_s) begin
            fifo_data_r[wr_ptr_r] <= oor_r ? {DATA_WIDTH{1'b0}} : rd_word_s;
            fifo_last_r[wr_ptr_r] <= last_beat_s;
            wr_ptr_r              <= ~wr_ptr_r;
            beat_r                <= beat_r + 8'd1;
            cur_w_r               <= (cur_w_r == WIDX_W'(TOTAL - 1)) ? {WIDX_W{1'b0}}
                                                                     : cur_w_r + WIDX_W'(1);
          end
        end
        default: begin
          beat_r <= 8'd0;
        end
      endcase
    end
  end

  assign bus.o_req_ready = ready_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_addr_err  = addr_err_r;
  assign bus.o_rsp_valid = (cnt_r != 2'd0);
  assign bus.o_rsp_rdata = fifo_data_r[rd_ptr_r];
  assign bus.o_rsp_last  = (cnt_r != 2'd0) && fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_pim_banked_buffer.sv
// Directed self-checking bench for pim_banked_buffer (default parameters).
module tb_pim_banked_buffer;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int BD    = 7168;
  localparam int TOTAL = NB * BD;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  pim_banked_buffer_if #(.DATA_WIDTH(DW)) bus();

  pim_banked_buffer #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] got_data [0:31];
  logic        got_last [0:31];
  logic        got_perr [0:31];
  int          got_cyc  [0:31];
  int          got_n;
  logic        err_c0, err_c1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    @(negedge i_clk);
    while (!bus.o_req_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check(tag, 32'(bus.o_req_ready), 32'd1);
  endtask

  task automatic req_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wait_ready("wr_ready");
    bus.i_req_valid = 1'b1;
    bus.i_req_write = 1'b1;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = data;
    bus.i_req_be    = be;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    bus.i_req_write = 1'b0;
    err_c0 = bus.o_addr_err;
  endtask

  // Issues a read and collects beats; stall_mask bit c drops i_rsp_ready on loop cycle c.
  // rst_at >= 0 asserts reset when that beat index is presented.
  task automatic req_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] stall_mask, input int rst_at);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        st;
    logic        did_rst;
    prev_stall = 1'b0;
    prev_data  = 32'd0;
    prev_last  = 1'b0;
    did_rst    = 1'b0;
    wait_ready("rd_ready");
    bus.i_req_valid     = 1'b1;
    bus.i_req_write     = 1'b0;
    bus.i_req_addr      = addr;
    bus.i_req_burst_len = len;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    got_n = 0;
    for (int c = 0; c < 100 && got_n < int'(len) + 1; c++) begin
      if (c == 0) err_c0 = bus.o_addr_err;
      if (c == 1) err_c1 = bus.o_addr_err;
      st = (c < 32) && stall_mask[c[4:0]];
      bus.i_rsp_ready = !st;
      if (rst_at >= 0 && got_n == rst_at && bus.o_rsp_valid) begin
        i_rstn = 1'b0;
        #1;
        check("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_last", 32'(bus.o_rsp_last), 32'd0);
        did_rst = 1'b1;
        break;
      end
      if (prev_stall && bus.o_rsp_valid) begin
        check("hold_data", bus.o_rsp_rdata, prev_data);
        check("hold_last", 32'(bus.o_rsp_last), 32'(prev_last));
      end
      if (st && bus.o_busy) check("ready_in_burst", 32'(bus.o_req_ready), 32'd0);
      if (bus.o_rsp_valid && !st) begin
        got_data[got_n] = bus.o_rsp_rdata;
        got_last[got_n] = bus.o_rsp_last;
`ifdef PIM_BUF_PARITY_EN
        got_perr[got_n] = bus.o_parity_err;
`else
        got_perr[got_n] = 1'b0;
`endif
        got_cyc[got_n]  = c;
        got_n++;
      end
      prev_stall = bus.o_rsp_valid && st;
      prev_data  = bus.o_rsp_rdata;
      prev_last  = bus.o_rsp_last;
      @(negedge i_clk);
    end
    bus.i_rsp_ready = 1'b1;
    if (!did_rst) begin
      check("beat_count", 32'(got_n), 32'(int'(len) + 1));
      check("no_extra", 32'(bus.o_rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    bus.i_req_valid     = 1'b0;
    bus.i_req_write     = 1'b0;
    bus.i_req_addr      = 32'd0;
    bus.i_req_wdata     = 32'd0;
    bus.i_req_be        = 4'd0;
    bus.i_req_burst_len = 8'd0;
    bus.i_rsp_ready     = 1'b1;
    err_c0 = 1'b0;
    err_c1 = 1'b0;

    // Reset values
    repeat (3) @(negedge i_clk);
    check("reset_ready", 32'(bus.o_req_ready), 32'd0);
    check("reset_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("reset_last", 32'(bus.o_rsp_last), 32'd0);
    check("reset_rdata", bus.o_rsp_rdata, 32'd0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_err", 32'(bus.o_addr_err), 32'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("ready_after_reset", 32'(bus.o_req_ready), 32'd1);

    // Partial byte-enable write
    req_write(32'h0, 32'h0000_0000, 4'hF);
    req_write(32'h0, 32'hDEAD_BEEF, 4'b0011);
    req_read(32'h0, 8'd0, 32'd0, -1);
    check("be_data", got_data[0], 32'h0000_BEEF);
    check("be_last", 32'(got_last[0]), 32'd1);

    // 8-beat burst, no backpressure
    for (int k = 0; k < 8; k++) req_write(32'(k * 4), 32'(k), 4'hF);
    req_read(32'h0, 8'd7, 32'd0, -1);
    for (int k = 0; k < 8; k++) begin
      check("burst_data", got_data[k], 32'(k));
      check("burst_last", 32'(got_last[k]), 32'(k == 7));
      if (k > 0) check("burst_consec", 32'(got_cyc[k] - got_cyc[k-1]), 32'd1);
    end

    // Same burst with ready low on loop cycles 2..4
    req_read(32'h0, 8'd7, 32'h0000_001C, -1);
    for (int k = 0; k < 8; k++) begin
      check("stall_data", got_data[k], 32'(k));
      check("stall_last", 32'(got_last[k]), 32'(k == 7));
    end

    // Wrap from the last word back to word 0
    req_write(32'h0, 32'h1234_5678, 4'hF);
    req_write(32'((TOTAL - 1) * 4), 32'hA5A5_0001, 4'hF);
    req_read(32'((TOTAL - 1) * 4), 8'd1, 32'd0, -1);
    check("wrap_data0", got_data[0], 32'hA5A5_0001);
    check("wrap_data1", got_data[1], 32'h1234_5678);
    check("wrap_last0", 32'(got_last[0]), 32'd0);
    check("wrap_last1", 32'(got_last[1]), 32'd1);
    check("wrap_noerr", 32'(err_c0), 32'd0);

    // Out-of-range read and write
    req_read(32'(TOTAL * 4), 8'd1, 32'd0, -1);
    check("oor_data0", got_data[0], 32'd0);
    check("oor_data1", got_data[1], 32'd0);
    check("oor_last1", 32'(got_last[1]), 32'd1);
    check("oor_err_pulse", 32'(err_c0), 32'd1);
    check("oor_err_clear", 32'(err_c1), 32'd0);
    req_write(32'(TOTAL * 4), 32'hFFFF_FFFF, 4'hF);
    check("oor_wr_err", 32'(err_c0), 32'd1);
    req_read(32'h0, 8'd0, 32'd0, -1);
    check("oor_wr_dropped", got_data[0], 32'h1234_5678);

    // Reset in the middle of a burst
    req_read(32'h0, 8'd7, 32'd0, 3);
    @(negedge i_clk);
    i_rstn = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid) vcnt++;
    end
    check("post_rst_no_beats", 32'(vcnt), 32'd0);
    req_read(32'h4, 8'd2, 32'd0, -1);
    check("mem_intact1", got_data[0], 32'd1);
    check("mem_intact2", got_data[1], 32'd2);
    check("mem_intact3", got_data[2], 32'd3);

`ifdef PIM_BUF_PARITY_EN
    // Single stored bit flip on word 5 (bank 1, row 1)
    req_write(32'd20, 32'h0F0F_0F0F, 4'hF);
    dut.mem_r[1][1][0] = ~dut.mem_r[1][1][0];
    req_read(32'd16, 8'd2, 32'd0, -1);
    check("perr_beat0", 32'(got_perr[0]), 32'd0);
    check("perr_beat1", 32'(got_perr[1]), 32'd1);
    check("perr_beat2", 32'(got_perr[2]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
